// File: rtl/hash_table_pkg.sv
// Shared types for the hash_table request/response path: op encoding, flag bit positions, requester FSM states.
package hash_table_pkg;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_READ   = 2'b01,
      OP_WRITE  = 2'b10,
      OP_DELETE = 2'b11
   } ht_op_e;

   // Bit positions inside the 4-bit flag/status word
   localparam int FLAG_KEY_PRESENT   = 3;
   localparam int FLAG_NO_ELEMENT    = 2;
   localparam int FLAG_NO_WRITE      = 1;
   localparam int FLAG_NO_DEL_TARGET = 0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      IDLE  = 2'd2
   } req_state_e;

   function automatic logic is_issuable(input logic [1:0] op);
      return op != OP_NOP;
   endfunction

endpackage

// File: rtl/hash_table_requester_if.sv
// Host-facing command/response bundle of hash_table_requester; master = host, slave = requester.
interface hash_table_requester_if #(
   parameter int KEY_WIDTH  = 2,
   parameter int DATA_WIDTH = 32
);
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [1:0]            cmd_op_i;
   logic [KEY_WIDTH-1:0]  cmd_key_i;
   logic [DATA_WIDTH-1:0] cmd_data_i;
   logic                  drain_i;
   logic                  idle_o;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [1:0]            rsp_op_o;
   logic [KEY_WIDTH-1:0]  rsp_key_o;
   logic [DATA_WIDTH-1:0] rsp_data_o;
   logic [3:0]            rsp_status_o;

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_key_i, cmd_data_i, drain_i, rsp_ready_i,
      input  cmd_ready_o, idle_o, rsp_valid_o, rsp_op_o, rsp_key_o, rsp_data_o, rsp_status_o
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_key_i, cmd_data_i, drain_i, rsp_ready_i,
      output cmd_ready_o, idle_o, rsp_valid_o, rsp_op_o, rsp_key_o, rsp_data_o, rsp_status_o
   );
endinterface

// File: rtl/ht_rsp_fifo.sv
// First-word-fall-through response FIFO; the head is held in a register so it keeps its last value when empty.
module ht_rsp_fifo #(
   parameter int WIDTH = 42,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             empty,
   output logic [WIDTH-1:0] rd_data
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [CNTW-1:0]  count_reg, count_next;
   logic [WIDTH-1:0] head_reg;
   logic             wr_en, rd_en;

   assign wr_en       = push & ((count_reg != CNTW'(DEPTH)) | pop);
   assign rd_en       = pop & (count_reg != '0);
   assign rd_ptr_next = rd_en ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

   always_comb begin
      count_next = count_reg;
      if (wr_en && !rd_en)
         count_next = count_reg + CNTW'(1);
      else if (!wr_en && rd_en)
         count_next = count_reg - CNTW'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= push_data;
   end

   // Next head comes from the array, or straight from the write port when that slot is written this cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         if (count_next != '0)
            head_reg <= (wr_en && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
      end
   end

   assign empty   = (count_reg == '0);
   assign rd_data = head_reg;

endmodule

// File: rtl/hash_table_requester.sv
// Issues host commands to hash_table, tracks them through its fixed-latency pipeline and returns in-order responses.
// Optional HT_REQ_CHECK_EN adds a sticky proto_err_o when ht_valid_i disagrees with the tracker.
module hash_table_requester
   import hash_table_pkg::*;
#(
   parameter int KEY_WIDTH    = 2,
   parameter int DATA_WIDTH   = 32,
   parameter int PIPE_LATENCY = 2,
   parameter int RSP_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   hash_table_requester_if.slave user,
   output logic [KEY_WIDTH-1:0]  ht_key_o,
   output logic [DATA_WIDTH-1:0] ht_data_o,
   output logic [1:0]            ht_op_o,
   output logic                  ht_valid_o,
   output logic                  ht_en_o,
   input  logic                  ht_valid_i,
   input  logic [DATA_WIDTH-1:0] ht_read_data_i,
   input  logic [3:0]            ht_flags_i
`ifdef HT_REQ_CHECK_EN
   ,
   output logic                  proto_err_o
`endif
);
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int EW = 2 + KEY_WIDTH + DATA_WIDTH + 4;

   req_state_e                state_reg, state_next;
   logic [CW-1:0]             credit_reg;
   logic                      en_reg;
   logic [PIPE_LATENCY-1:0]   trk_valid_reg, trk_valid_next;
   logic [1:0]                trk_op_reg  [PIPE_LATENCY];
   logic [1:0]                trk_op_next [PIPE_LATENCY];
   logic [KEY_WIDTH-1:0]      trk_key_reg  [PIPE_LATENCY];
   logic [KEY_WIDTH-1:0]      trk_key_next [PIPE_LATENCY];
   logic                      issue, pop, tail_valid, fifo_empty;
   logic [1:0]                tail_op;
   logic [EW-1:0]             push_data, fifo_rd_data;

   assign user.cmd_ready_o = reset & (state_reg == RUN) & ~user.drain_i & (credit_reg != '0);
   assign issue            = user.cmd_valid_i & user.cmd_ready_o & is_issuable(user.cmd_op_i);

   assign ht_key_o   = reset ? user.cmd_key_i  : '0;
   assign ht_data_o  = reset ? user.cmd_data_i : '0;
   assign ht_op_o    = reset ? user.cmd_op_i   : 2'b00;
   assign ht_valid_o = issue;
   assign ht_en_o    = en_reg;

   // Tracker mirrors the hash_table pipeline; the last slot lines up with ht_valid_i
   for (genvar gi = 0; gi < PIPE_LATENCY; gi++) begin : g_trk
      if (gi == 0) begin : g_head
         assign trk_valid_next[gi] = issue;
         assign trk_op_next[gi]    = user.cmd_op_i;
         assign trk_key_next[gi]   = user.cmd_key_i;
      end else begin : g_shift
         assign trk_valid_next[gi] = trk_valid_reg[gi-1];
         assign trk_op_next[gi]    = trk_op_reg[gi-1];
         assign trk_key_next[gi]   = trk_key_reg[gi-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         trk_valid_reg <= '0;
         for (int i = 0; i < PIPE_LATENCY; i++) begin
            trk_op_reg[i]  <= 2'b00;
            trk_key_reg[i] <= '0;
         end
         en_reg <= 1'b0;
      end else begin
         trk_valid_reg <= trk_valid_next;
         trk_op_reg    <= trk_op_next;
         trk_key_reg   <= trk_key_next;
         en_reg        <= 1'b1;
      end
   end

   assign tail_valid = trk_valid_reg[PIPE_LATENCY-1];
   assign tail_op    = trk_op_reg[PIPE_LATENCY-1];
   assign push_data  = {tail_op, trk_key_reg[PIPE_LATENCY-1],
                        (tail_op == OP_READ) ? ht_read_data_i : {DATA_WIDTH{1'b0}}, ht_flags_i};
   assign pop        = user.rsp_valid_o & user.rsp_ready_i;

   ht_rsp_fifo #(.WIDTH(EW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tail_valid),
      .push_data (push_data),
      .pop       (pop),
      .empty     (fifo_empty),
      .rd_data   (fifo_rd_data)
   );

   assign user.rsp_valid_o = ~fifo_empty;
   assign {user.rsp_op_o, user.rsp_key_o, user.rsp_data_o, user.rsp_status_o} = fifo_rd_data;

   // A credit is a reserved FIFO slot, so every op in flight is guaranteed somewhere to land
   always_ff @(posedge clk) begin
      if (!reset)
         credit_reg <= CW'(RSP_DEPTH);
      else if (issue && !pop)
         credit_reg <= credit_reg - CW'(1);
      else if (!issue && pop)
         credit_reg <= credit_reg + CW'(1);
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (user.drain_i) state_next = DRAIN;
         DRAIN:   if ((trk_valid_reg == '0) && fifo_empty) state_next = IDLE;
         IDLE:    if (!user.drain_i) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset)
         state_reg <= RUN;
      else
         state_reg <= state_next;
   end

   assign user.idle_o = reset & (state_reg == IDLE);

`ifdef HT_REQ_CHECK_EN
   always_ff @(posedge clk) begin
      if (!reset)
         proto_err_o <= 1'b0;
      else if (ht_valid_i != tail_valid)
         proto_err_o <= 1'b1;
   end
`else
   logic unused_ht_valid;
   assign unused_ht_valid = ht_valid_i;
`endif

endmodule
